// File: rtl/alu_share_arb_pkg.sv
// Shared encodings and payload type for the two-requester ALU arbiter.
package alu_share_arb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3_W = 3;
    localparam int unsigned F7_W = 7;
    localparam int unsigned NREQ = 2;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SL   = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SR   = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic REQ_EX  = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef struct packed {
        logic            op;
        logic            op_imm;
        logic [F3_W-1:0] funct3;
        logic [F7_W-1:0] funct7;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational integer ALU; result is meaningless for illegal encodings.
module alu_share_arb_alu
    import alu_share_arb_pkg::*;
(
    input  alu_req_t        req,
    output logic [XLEN-1:0] result_c
);

    logic shamt_big;

    // Full 32-bit b: any amount of 32 or more shifts everything out.
    assign shamt_big = |req.b[XLEN-1:5];

    always_comb begin
        result_c = '0;
        case (req.funct3)
            F3_ADD:  result_c = (!req.op_imm && req.funct7 == F7_ALT) ? req.a - req.b
                                                                      : req.a + req.b;
            F3_SL:   result_c = shamt_big ? '0 : req.a << req.b[4:0];
            F3_SLT:  result_c = XLEN'($signed(req.a) < $signed(req.b));
            F3_SLTU: result_c = XLEN'(req.a < req.b);
            F3_XOR:  result_c = req.a ^ req.b;
            F3_SR: begin
                if (req.funct7 == F7_ALT) begin
                    result_c = shamt_big ? {XLEN{req.a[XLEN-1]}}
                                         : XLEN'($signed(req.a) >>> req.b[4:0]);
                end else begin
                    result_c = shamt_big ? '0 : req.a >> req.b[4:0];
                end
            end
            F3_OR:   result_c = req.a | req.b;
            F3_AND:  result_c = req.a & req.b;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates two requesters onto one ALU and registers the result into a
// one-entry tagged response slot with valid/ready on both sides.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_op,
    input  logic [NREQ-1:0]            req_op_imm,
    input  logic [NREQ-1:0][F3_W-1:0]  req_funct3,
    input  logic [NREQ-1:0][F7_W-1:0]  req_funct7,
    input  logic [NREQ-1:0][XLEN-1:0]  req_a,
    input  logic [NREQ-1:0][XLEN-1:0]  req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [XLEN-1:0]            rsp_data,
    output logic                       rsp_err
);

    logic            rr_ptr;
    logic            can_accept_c;
    logic [NREQ-1:0] grant_c;
    logic            xfer_c;
    logic            win_c;
    logic            illegal_c;
    alu_req_t        sel_req_c;
    logic [XLEN-1:0] alu_result_c;

    // Grant: slot must be free or draining; both valid resolves by priority mode.
    always_comb begin
        grant_c      = '0;
        can_accept_c = !rsp_valid || rsp_ready;
        if (rst_n && can_accept_c) begin
            if (req_valid == 2'b11) begin
                grant_c = (FIXED_PRIO || !rr_ptr) ? 2'b01 : 2'b10;
            end else begin
                grant_c = req_valid;
            end
        end
    end

    assign req_ready = grant_c;
    assign xfer_c    = |(req_valid & grant_c);
    assign win_c     = grant_c[1];

    // Operand mux; an ungranted requester's payload never reaches the ALU.
    always_comb begin
        sel_req_c = '0;
        if (grant_c[0]) begin
            sel_req_c = '{op: req_op[0], op_imm: req_op_imm[0], funct3: req_funct3[0],
                          funct7: req_funct7[0], a: req_a[0], b: req_b[0]};
        end else if (grant_c[1]) begin
            sel_req_c = '{op: req_op[1], op_imm: req_op_imm[1], funct3: req_funct3[1],
                          funct7: req_funct7[1], a: req_a[1], b: req_b[1]};
        end
    end

    always_comb begin
        illegal_c = 1'b0;
        if (!sel_req_c.op) begin
            illegal_c = 1'b1;
        end else if (sel_req_c.funct3 == F3_ADD && !sel_req_c.op_imm &&
                     sel_req_c.funct7 != F7_BASE && sel_req_c.funct7 != F7_ALT) begin
            illegal_c = 1'b1;
        end else if (sel_req_c.funct3 == F3_SR &&
                     sel_req_c.funct7 != F7_BASE && sel_req_c.funct7 != F7_ALT) begin
            illegal_c = 1'b1;
        end
    end

    alu_share_arb_alu alu (
        .req      (sel_req_c),
        .result_c (alu_result_c)
    );

    // Response slot and round-robin pointer; pointer only moves on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= REQ_EX;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (xfer_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= win_c;
            rsp_data  <= illegal_c ? '0 : alu_result_c;
            rsp_err   <= illegal_c;
            rr_ptr    <= ~win_c;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed literal checks plus randomized traffic
// compared every cycle against an in-bench behavioural model.
module tb_alu_share_arb;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op;
    logic [1:0]       req_op_imm;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][6:0]  req_funct7;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: slot contents, turn pointer, last-edge transfers.
    bit          m_valid = 1'b0;
    bit          m_id    = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_data  = 32'h0;
    bit          m_rr    = 1'b0;
    bit   [1:0]  m_xfer  = 2'b00;

    alu_share_arb #(.FIXED_PRIO(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_op_imm (req_op_imm),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic chk_rsp(input string name, input bit v, input bit id, input bit err,
                           input logic [31:0] data);
        chk(name, 64'({rsp_valid, rsp_id, rsp_err, rsp_data}), 64'({v, id, err, data}));
    endtask

    function automatic logic [1:0] model_grant();
        if (!rst_n) return 2'b00;
        if (m_valid && !rsp_ready) return 2'b00;
        if (req_valid == 2'b11) return m_rr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    // Returns {illegal, result} straight from the operation definitions.
    function automatic logic [32:0] model_alu(input bit op, input bit imm, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = a;
        if (!op) return {1'b1, 32'h0};
        case (f3)
            3'd0: begin
                if (imm || f7 == 7'h00) r = a + b;
                else if (f7 == 7'h20) r = a - b;
                else return {1'b1, 32'h0};
            end
            3'd1: for (int k = 0; k < 32; k++) if (32'(k) < b) r = r << 1;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f7 == 7'h00) begin
                    for (int k = 0; k < 32; k++) if (32'(k) < b) r = r >> 1;
                end else if (f7 == 7'h20) begin
                    for (int k = 0; k < 32; k++) if (32'(k) < b) r = {r[31], r[31:1]};
                end else begin
                    return {1'b1, 32'h0};
                end
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {1'b0, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [1:0]  g;
        logic [32:0] res;
        bit          w;
        if (!rst_n) begin
            m_valid <= 1'b0; m_id <= 1'b0; m_err <= 1'b0; m_data <= 32'h0;
            m_rr <= 1'b0; m_xfer <= 2'b00;
        end else begin
            g = model_grant() & req_valid;
            m_xfer <= g;
            if (g != 2'b00) begin
                w   = g[1];
                res = model_alu(req_op[w], req_op_imm[w], req_funct3[w], req_funct7[w],
                                req_a[w], req_b[w]);
                m_valid <= 1'b1;
                m_id    <= w;
                m_err   <= res[32];
                m_data  <= res[31:0];
                m_rr    <= !w;
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(model_grant()));
            chk("rsp_slot", 64'({rsp_valid, rsp_id, rsp_err, rsp_data}),
                64'({m_valid, m_id, m_err, m_data}));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input bit op, input bit imm, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]  = 1'b1;
        req_op[i]     = op;
        req_op_imm[i] = imm;
        req_funct3[i] = f3;
        req_funct7[i] = f7;
        req_a[i]      = a;
        req_b[i]      = b;
    endtask

    task automatic issue0(input string name, input bit op, input bit imm, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input bit err, input logic [31:0] data);
        set_req(0, op, imm, f3, f7, a, b);
        step();
        req_valid[0] = 1'b0;
        chk_rsp(name, 1'b1, 1'b0, err, data);
    endtask

    task automatic rand_req(input int i);
        int unsigned sel;
        req_valid[i]  = ($urandom_range(0, 3) != 0);
        req_op[i]     = ($urandom_range(0, 15) != 0);
        req_op_imm[i] = 1'($urandom);
        req_funct3[i] = 3'($urandom);
        sel = $urandom_range(0, 3);
        req_funct7[i] = (sel == 1) ? 7'h20 : (sel == 3) ? 7'($urandom) : 7'h00;
        req_a[i]      = $urandom;
        req_b[i]      = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
    endtask

    initial begin
        req_valid = '0; req_op = '0; req_op_imm = '0; req_funct3 = '0; req_funct7 = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b1;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #2;
        chk_rsp("reset_rsp", 1'b0, 1'b0, 1'b0, 32'h0);
        set_req(0, 1'b1, 1'b0, 3'd0, 7'h00, 32'd5, 32'd7);
        #1 chk("reset_ready", 64'(req_ready), 64'(2'b00));

        // Single request right after reset.
        step();
        rst_n = 1'b1;
        step();
        req_valid = 2'b00;
        chk_rsp("add_5_7", 1'b1, 1'b0, 1'b0, 32'd12);

        // I-form ADD ignores funct7; also leaves the turn with requester 0.
        set_req(1, 1'b1, 1'b1, 3'd0, 7'h20, 32'd1, 32'd2);
        step();
        req_valid = 2'b00;
        chk_rsp("addi_f7alt", 1'b1, 1'b1, 1'b0, 32'd3);

        // Contention alternates.
        set_req(0, 1'b1, 1'b0, 3'd0, 7'h20, 32'd10, 32'd3);
        set_req(1, 1'b1, 1'b0, 3'd4, 7'h00, 32'h0000_00F0, 32'h0000_000F);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_rsp($sformatf("contend%0d", k), 1'b1, 1'(k % 2), 1'b0,
                    (k % 2 == 1) ? 32'h0000_00FF : 32'd7);
        end

        // Backpressure holds slot and turn.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("stall_ready%0d", k), 64'(req_ready), 64'(2'b00));
            step();
            chk_rsp($sformatf("stall_rsp%0d", k), 1'b1, 1'b1, 1'b0, 32'h0000_00FF);
        end
        rsp_ready = 1'b1;
        #1 chk("release_ready", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = 2'b00;
        chk_rsp("release_rsp", 1'b1, 1'b0, 1'b0, 32'd7);

        // Arithmetic edges and illegal encodings.
        issue0("sra_4",     1'b1, 1'b0, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000);
        issue0("slt_m1_1",  1'b1, 1'b0, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);
        issue0("sltu_m1_1", 1'b1, 1'b0, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        issue0("op0",       1'b0, 1'b0, 3'd0, 7'h00, 32'd4, 32'd4, 1'b1, 32'h0);
        issue0("add_f7_1",  1'b1, 1'b0, 3'd0, 7'h01, 32'd4, 32'd4, 1'b1, 32'h0);
        issue0("sr_f7_1",   1'b1, 1'b1, 3'd5, 7'h01, 32'd4, 32'd1, 1'b1, 32'h0);
        issue0("sl_40",     1'b1, 1'b0, 3'd1, 7'h00, 32'd1, 32'd40, 1'b0, 32'h0);
        issue0("sra_100",   1'b1, 1'b0, 3'd5, 7'h20, 32'h8000_0000, 32'd100, 1'b0, 32'hFFFF_FFFF);
        issue0("sub_neg",   1'b1, 1'b0, 3'd0, 7'h20, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE);

        // Async reset mid-stall; turn pointer currently favours requester 1.
        issue0("pre_reset", 1'b1, 1'b0, 3'd0, 7'h00, 32'd1, 32'd1, 1'b0, 32'd2);
        rsp_ready = 1'b0;
        step();
        #1 rst_n = 1'b0;
        #1 chk("async_valid", 64'(rsp_valid), 64'(1'b0));
        chk("async_ready", 64'(req_ready), 64'(2'b00));
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 3'd0, 7'h20, 32'd10, 32'd3);
        set_req(1, 1'b1, 1'b0, 3'd4, 7'h00, 32'h0000_00F0, 32'h0000_000F);
        step();
        rst_n = 1'b1;
        step();
        chk_rsp("post_reset_grant", 1'b1, 1'b0, 1'b0, 32'd7);
        req_valid[0] = 1'b0;

        // Randomized traffic; a pending request holds until accepted.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || m_xfer[i]) rand_req(i);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
